// File: rtl/tmds_decoder.sv
// TMDS channel receiver: aligns the deserialized 10-bit stream, then decodes control tokens and pixel data.
// Define TMDS_ERR_COUNT_EN to add the saturating lock-loss counter output err_count.
module tmds_decoder #(
  parameter int LOCK_RUN = 8,
  parameter int TIMEOUT  = 2048
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] raw,
  output logic [7:0] data,
  output logic [1:0] c,
  output logic       de,
  output logic       locked,
  output logic [3:0] slip_pos
`ifdef TMDS_ERR_COUNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [7:0]  RUN_MAX  = 8'(LOCK_RUN);
  localparam logic [15:0] IDLE_MAX = 16'(TIMEOUT - 1);

  // Returns {is_token, c1, c0} for the four control symbols.
  function automatic logic [2:0] tok_decode(input logic [9:0] sym);
    logic [2:0] r;
    case (sym)
      10'b1101010100: r = 3'b100;
      10'b0010101011: r = 3'b101;
      10'b0101010100: r = 3'b110;
      10'b1010101011: r = 3'b111;
      default:        r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] data_decode(input logic [9:0] sym);
    logic [7:0] d;
    logic [7:0] o;
    d    = sym[9] ? ~sym[7:0] : sym[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

  state_t      state_r, state_next;
  logic [3:0]  slip_r, slip_next;
  logic [7:0]  run_r, run_next;
  logic [15:0] idle_r, idle_next;
  logic [9:0]  raw_prev_r;
  logic [9:0]  s1_r;
  logic [7:0]  data_r, data_next;
  logic [1:0]  c_r, c_next;
  logic        de_r, de_next;
  logic        lost_s;
  logic [19:0] w_s;
  logic [9:0]  a_s;
  logic [2:0]  tok_a_s;
  logic [2:0]  tok_s1_s;

  assign w_s      = {raw, raw_prev_r};
  assign a_s      = w_s[slip_r +: 10];
  assign tok_a_s  = tok_decode(a_s);
  assign tok_s1_s = tok_decode(s1_r);

  // Alignment FSM: a token takes priority over the idle timeout, which slips the window by one bit.
  always_comb begin
    state_next = state_r;
    slip_next  = slip_r;
    run_next   = run_r;
    idle_next  = idle_r;
    lost_s     = 1'b0;
    if (tok_a_s[2]) begin
      idle_next = 16'd0;
      if (run_r != RUN_MAX) begin
        run_next = run_r + 8'd1;
      end else begin
        run_next = run_r;
      end
      if ((state_r == HUNT) && (run_next == RUN_MAX)) begin
        state_next = LOCKED;
      end else begin
        state_next = state_r;
      end
    end else if (idle_r == IDLE_MAX) begin
      slip_next  = (slip_r == 4'd9) ? 4'd0 : slip_r + 4'd1;
      run_next   = 8'd0;
      idle_next  = 16'd0;
      state_next = HUNT;
      lost_s     = (state_r == LOCKED);
    end else begin
      run_next  = 8'd0;
      idle_next = idle_r + 16'd1;
    end
  end

  // Stage-2 output selection; gated by the state being entered so locked and de stay coherent.
  always_comb begin
    data_next = 8'd0;
    c_next    = 2'b00;
    de_next   = 1'b0;
    case (state_next)
      LOCKED: begin
        if (tok_s1_s[2]) begin
          c_next = tok_s1_s[1:0];
        end else begin
          de_next   = 1'b1;
          data_next = data_decode(s1_r);
          c_next    = c_r;
        end
      end
      HUNT: begin
        c_next = 2'b00;
      end
      default: begin
        c_next = 2'b00;
      end
    endcase
  end

  // State, counters, pipeline stages and registered outputs.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_r    <= HUNT;
      slip_r     <= 4'd0;
      run_r      <= 8'd0;
      idle_r     <= 16'd0;
      raw_prev_r <= 10'd0;
      s1_r       <= 10'd0;
      data_r     <= 8'd0;
      c_r        <= 2'b00;
      de_r       <= 1'b0;
    end else begin
      state_r    <= state_next;
      slip_r     <= slip_next;
      run_r      <= run_next;
      idle_r     <= idle_next;
      raw_prev_r <= raw;
      s1_r       <= a_s;
      data_r     <= data_next;
      c_r        <= c_next;
      de_r       <= de_next;
    end
  end

`ifdef TMDS_ERR_COUNT_EN
  logic [15:0] err_r;

  // Saturating count of LOCKED to HUNT transitions.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      err_r <= 16'd0;
    end else if (lost_s && (err_r != 16'hFFFF)) begin
      err_r <= err_r + 16'd1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_count = err_r;
`else
  logic unused_lost_s;
  assign unused_lost_s = lost_s;
`endif

  assign data     = data_r;
  assign c        = c_r;
  assign de       = de_r;
  assign locked   = (state_r == LOCKED);
  assign slip_pos = slip_r;

endmodule
